// File: rtl/motor_drive_sequencer_pkg.sv
// rtl/motor_drive_sequencer_pkg.sv - command codes, sequencer states and direction mapping
// Shared by the sequencer top, its handshake interface users and the bench-facing encoding.
package motor_pkg;

    localparam logic [1:0] STOP    = 2'b00;
    localparam logic [1:0] FORWARD = 2'b01;
    localparam logic [1:0] RIGHT   = 2'b10;
    localparam logic [1:0] LEFT    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP_DOWN,
        S_DEAD,
        S_RAMP_UP,
        S_RUN
    } state_t;

    // Bridge enables as {a_fwd, a_rev, b_fwd, b_rev}; no command sets both bits of a pair.
    function automatic logic [3:0] dir_mask(input logic [1:0] cmd);
        case (cmd)
            FORWARD: dir_mask = 4'b1010;
            RIGHT:   dir_mask = 4'b1001;
            LEFT:    dir_mask = 4'b0110;
            default: dir_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/motor_drive_sequencer_if.sv
// rtl/motor_drive_sequencer_if.sv - command handshake bundle between requesters and the sequencer
// Signals:
//   nav_valid/nav_cmd/nav_ready  navigation command handshake
//   ovr_valid/ovr_cmd/ovr_ready  override command handshake (never refused)
//   duty_target                  duty latched with whichever command is accepted
// master: command source side; slave: sequencer side.
interface motor_drive_sequencer_if;

    logic       nav_valid;
    logic [1:0] nav_cmd;
    logic       nav_ready;
    logic       ovr_valid;
    logic [1:0] ovr_cmd;
    logic       ovr_ready;
    logic [7:0] duty_target;

    modport master (
        output nav_valid, nav_cmd, ovr_valid, ovr_cmd, duty_target,
        input  nav_ready, ovr_ready
    );

    modport slave (
        input  nav_valid, nav_cmd, ovr_valid, ovr_cmd, duty_target,
        output nav_ready, ovr_ready
    );

endinterface

// File: rtl/motor_drive_sequencer_pwm_gen.sv
// rtl/motor_drive_sequencer_pwm_gen.sv - free-running PWM prescaler, 8-bit counter and duty compare
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   duty        current duty, 0..255
//   pwm_on      high while duty > pwm counter (combinational compare)
module pwm_gen #(
    parameter int PWM_PRESCALE = 39
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] duty,
    output logic       pwm_on
);

    localparam int PW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

    logic [PW-1:0] prescale;
    logic [7:0]    pwm_cnt;

    // Only reset clears the counter; command traffic never disturbs the PWM phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescale <= '0;
            pwm_cnt  <= '0;
        end else if (prescale == PW'(PWM_PRESCALE - 1)) begin
            prescale <= '0;
            pwm_cnt  <= pwm_cnt + 8'd1;
        end else begin
            prescale <= prescale + PW'(1);
        end
    end

    // duty 0 never turns on, duty 255 is on for 255 of 256 counts.
    assign pwm_on = duty > pwm_cnt;

endmodule

// File: rtl/motor_drive_sequencer.sv
// rtl/motor_drive_sequencer.sv - direction-change sequencer: ramp down, dead time, ramp up, with override
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   bus (slave)                 nav/override command handshakes and duty_target
//   motor_a_fwd .. motor_b_rev  registered H-bridge inputs
//   cur_cmd                     direction currently driven
//   busy                        high while ramping down, in dead time or ramping up
module motor_drive_sequencer
    import motor_pkg::*;
#(
    parameter int PWM_PRESCALE = 39,
    parameter int RAMP_DIV     = 16,
    parameter int DEAD_CYCLES  = 500
) (
    input  logic                   clk,
    input  logic                   reset,
    motor_drive_sequencer_if.slave bus,
    output logic                   motor_a_fwd,
    output logic                   motor_a_rev,
    output logic                   motor_b_fwd,
    output logic                   motor_b_rev,
    output logic [1:0]             cur_cmd,
    output logic                   busy
);

    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    state_t        state;
    logic [7:0]    duty;
    logic [7:0]    pending_duty;
    logic [1:0]    pending_cmd;
    logic [RW-1:0] ramp_cnt;
    logic [DW-1:0] dead_cnt;
    logic [3:0]    motor;
    logic          pwm_on;

    logic          accept;
    logic          emergency;
    logic          ramp_tick;
    logic          dead_done;
    logic [1:0]    in_cmd;
    logic [1:0]    next_pcmd;
    logic [7:0]    next_pduty;

    pwm_gen #(.PWM_PRESCALE(PWM_PRESCALE)) u_pwm (
        .clk    (clk),
        .reset  (reset),
        .duty   (duty),
        .pwm_on (pwm_on)
    );

    // Override always wins the arbitration; nav only gets through when settled.
    assign bus.ovr_ready = 1'b1;
    assign bus.nav_ready = ((state == S_IDLE) || (state == S_RUN)) && !bus.ovr_valid;

    assign accept     = bus.ovr_valid || (bus.nav_valid && bus.nav_ready);
    assign in_cmd     = bus.ovr_valid ? bus.ovr_cmd : bus.nav_cmd;
    assign emergency  = bus.ovr_valid && (bus.ovr_cmd == STOP);
    assign ramp_tick  = ramp_cnt == RW'(RAMP_DIV - 1);
    assign dead_done  = dead_cnt == DW'(DEAD_CYCLES - 1);

    // Outside IDLE/RUN only an override can arrive; it replaces the pending target.
    assign next_pcmd  = bus.ovr_valid ? bus.ovr_cmd : pending_cmd;
    assign next_pduty = bus.ovr_valid ? bus.duty_target : pending_duty;

    assign motor_a_fwd = motor[3];
    assign motor_a_rev = motor[2];
    assign motor_b_fwd = motor[1];
    assign motor_b_rev = motor[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            duty         <= 8'd0;
            pending_cmd  <= STOP;
            pending_duty <= 8'd0;
            cur_cmd      <= STOP;
            ramp_cnt     <= '0;
            dead_cnt     <= '0;
            motor        <= 4'b0000;
            busy         <= 1'b0;
        end else begin
            // Default drive; the branches below force it low when entering or sitting in dead time.
            motor <= dir_mask(cur_cmd) & {4{pwm_on}};

            if (emergency) begin
                // Emergency stop: drop the bridge immediately and always run a full dead time.
                state        <= S_DEAD;
                busy         <= 1'b1;
                duty         <= 8'd0;
                pending_cmd  <= STOP;
                pending_duty <= 8'd0;
                dead_cnt     <= '0;
                motor        <= 4'b0000;
            end else begin
                case (state)
                    S_IDLE, S_RUN: begin
                        // Same direction completes the handshake with no effect, duty included.
                        if (accept && (in_cmd != cur_cmd)) begin
                            pending_cmd  <= in_cmd;
                            pending_duty <= bus.duty_target;
                            state        <= S_RAMP_DOWN;
                            busy         <= 1'b1;
                            ramp_cnt     <= '0;
                        end
                    end

                    S_RAMP_DOWN: begin
                        pending_cmd  <= next_pcmd;
                        pending_duty <= next_pduty;
                        if (duty == 8'd0) begin
                            state    <= S_DEAD;
                            dead_cnt <= '0;
                            motor    <= 4'b0000;
                        end else if (ramp_tick) begin
                            ramp_cnt <= '0;
                            duty     <= duty - 8'd1;
                            // Enter dead time on the same edge duty reaches zero.
                            if (duty == 8'd1) begin
                                state    <= S_DEAD;
                                dead_cnt <= '0;
                                motor    <= 4'b0000;
                            end
                        end else begin
                            ramp_cnt <= ramp_cnt + RW'(1);
                        end
                    end

                    S_DEAD: begin
                        pending_cmd  <= next_pcmd;
                        pending_duty <= next_pduty;
                        motor        <= 4'b0000;
                        if (dead_done) begin
                            cur_cmd <= next_pcmd;
                            if (next_pcmd == STOP) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end else if (next_pduty == 8'd0) begin
                                state <= S_RUN;
                                busy  <= 1'b0;
                            end else begin
                                state    <= S_RAMP_UP;
                                ramp_cnt <= '0;
                            end
                        end else begin
                            dead_cnt <= dead_cnt + DW'(1);
                        end
                    end

                    S_RAMP_UP: begin
                        if (bus.ovr_valid) begin
                            pending_cmd  <= bus.ovr_cmd;
                            pending_duty <= bus.duty_target;
                            state        <= S_RAMP_DOWN;
                            ramp_cnt     <= '0;
                        end else if (ramp_tick) begin
                            // duty < pending_duty here, so the increment cannot pass 255.
                            ramp_cnt <= '0;
                            duty     <= duty + 8'd1;
                            if ((duty + 8'd1) == pending_duty) begin
                                state <= S_RUN;
                                busy  <= 1'b0;
                            end
                        end else begin
                            ramp_cnt <= ramp_cnt + RW'(1);
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// tb/tb_motor_drive_sequencer.sv - self-checking bench for motor_drive_sequencer
module tb_motor_drive_sequencer;

    localparam int PRE = 1;
    localparam int RD  = 4;
    localparam int DC  = 8;

    localparam int C_STOP    = 0;
    localparam int C_FORWARD = 1;
    localparam int C_RIGHT   = 2;
    localparam int C_LEFT    = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_fwd, a_rev, b_fwd, b_rev;
    logic [1:0] cur_cmd;
    logic       busy;

    motor_drive_sequencer_if bus();

    motor_drive_sequencer #(
        .PWM_PRESCALE (PRE),
        .RAMP_DIV     (RD),
        .DEAD_CYCLES  (DC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .motor_a_fwd (a_fwd),
        .motor_a_rev (a_rev),
        .motor_b_fwd (b_fwd),
        .motor_b_rev (b_rev),
        .cur_cmd     (cur_cmd),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: settled direction and duty only.
    int m_cmd  = C_STOP;
    int m_duty = 0;

    // Background monitor: shoot-through and the zero-output stretch preceding each direction change.
    int         overlap   = 0;
    int         zero_run  = 0;
    int         min_dead  = 1000000;
    int         dead_seen = 0;
    bit         mon_en    = 1'b0;
    logic [1:0] prev_cmd  = 2'b00;

    always @(negedge clk) begin
        if ((a_fwd && a_rev) || (b_fwd && b_rev))
            overlap <= overlap + 1;
        if (!a_fwd && !a_rev && !b_fwd && !b_rev)
            zero_run <= zero_run + 1;
        else
            zero_run <= 0;
        if (mon_en && (cur_cmd !== prev_cmd)) begin
            dead_seen <= dead_seen + 1;
            if (zero_run < min_dead)
                min_dead <= zero_run;
        end
        prev_cmd <= cur_cmd;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // {a_fwd, a_rev, b_fwd, b_rev} from the command table.
    function automatic logic [3:0] spec_mask(input int cmd);
        case (cmd)
            C_FORWARD: return 4'b1010;
            C_RIGHT:   return 4'b1001;
            C_LEFT:    return 4'b0110;
            default:   return 4'b0000;
        endcase
    endfunction

    // Busy length: ramp down (1 cycle if already at 0), dead time, ramp up unless stopping.
    function automatic int exp_busy(input int cur_c, input int cur_d, input int new_c, input int new_d);
        int t;
        if (new_c == cur_c) return 0;
        t = (cur_d == 0) ? 1 : cur_d * RD;
        t += DC;
        if (new_c != C_STOP) t += new_d * RD;
        return t;
    endfunction

    task automatic issue(input bit ovr, input int cmd, input int d);
        @(negedge clk);
        bus.duty_target = d[7:0];
        if (ovr) begin
            bus.ovr_valid = 1'b1;
            bus.ovr_cmd   = cmd[1:0];
        end else begin
            bus.nav_valid = 1'b1;
            bus.nav_cmd   = cmd[1:0];
        end
        @(posedge clk);
        #1;
        bus.ovr_valid = 1'b0;
        bus.nav_valid = 1'b0;
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        while (n < 5000) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: observed busy for %0d cycles, expected idle", n);
        end
    endtask

    task automatic check_pwm(input string tag);
        int na, nar, nb, nbr;
        logic [3:0] m;
        na = 0; nar = 0; nb = 0; nbr = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            na  += int'(a_fwd);
            nar += int'(a_rev);
            nb  += int'(b_fwd);
            nbr += int'(b_rev);
        end
        m = spec_mask(m_cmd);
        chk({tag, "_on_a_fwd"}, na,  m[3] ? m_duty : 0);
        chk({tag, "_on_a_rev"}, nar, m[2] ? m_duty : 0);
        chk({tag, "_on_b_fwd"}, nb,  m[1] ? m_duty : 0);
        chk({tag, "_on_b_rev"}, nbr, m[0] ? m_duty : 0);
    endtask

    task automatic step(input bit ovr, input int cmd, input int d, input string tag);
        int n, e;
        if (ovr && cmd == C_STOP) e = DC;
        else e = exp_busy(m_cmd, m_duty, cmd, d);
        issue(ovr, cmd, d);
        measure_busy(n);
        chk({tag, "_busy_cycles"}, n, e);
        if (ovr && cmd == C_STOP) begin
            m_cmd = C_STOP;
            m_duty = 0;
        end else if (cmd != m_cmd) begin
            m_cmd = cmd;
            m_duty = (cmd == C_STOP) ? 0 : d;
        end
        chk({tag, "_cur_cmd"}, int'(cur_cmd), m_cmd);
        check_pwm(tag);
    endtask

    initial begin
        int n;
        bus.nav_valid   = 1'b0;
        bus.nav_cmd     = 2'b00;
        bus.ovr_valid   = 1'b0;
        bus.ovr_cmd     = 2'b00;
        bus.duty_target = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({a_fwd, a_rev, b_fwd, b_rev}), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_cur_cmd", int'(cur_cmd), C_STOP);
        chk("reset_nav_ready", int'(bus.nav_ready), 1);
        chk("reset_ovr_ready", int'(bus.ovr_ready), 1);
        reset = 1'b0;
        #1 mon_en = 1'b1;

        // 1: IDLE -> FORWARD 128
        step(1'b0, C_FORWARD, 128, "s1_fwd128");
        // 3: resubmit same direction with a different duty
        step(1'b0, C_FORWARD, 200, "s3_same_cmd");
        // 2: FORWARD -> RIGHT
        step(1'b0, C_RIGHT, 100, "s2_right");
        // Emergency stop from RUN
        step(1'b1, C_STOP, 0, "estop_run");

        // 4: emergency stop during RAMP_UP at duty 40
        issue(1'b0, C_FORWARD, 128);
        repeat (169) @(negedge clk);
        chk("s4_busy_before_stop", int'(busy), 1);
        issue(1'b1, C_STOP, 0);
        @(negedge clk);
        chk("s4_outputs_next_cycle", int'({a_fwd, a_rev, b_fwd, b_rev}), 0);
        chk("s4_busy_dead", int'(busy), 1);
        measure_busy(n);
        chk("s4_dead_rest", n, DC - 1);
        chk("s4_cur_cmd", int'(cur_cmd), C_STOP);
        m_cmd = C_STOP;
        m_duty = 0;
        check_pwm("s4_idle");

        // 5: simultaneous nav and override in RUN
        step(1'b0, C_FORWARD, 50, "s5_setup");
        @(negedge clk);
        bus.nav_valid   = 1'b1;
        bus.nav_cmd     = 2'(C_LEFT);
        bus.ovr_valid   = 1'b1;
        bus.ovr_cmd     = 2'(C_RIGHT);
        bus.duty_target = 8'd30;
        #1;
        chk("s5_nav_ready_blocked", int'(bus.nav_ready), 0);
        chk("s5_ovr_ready", int'(bus.ovr_ready), 1);
        @(posedge clk);
        #1;
        bus.ovr_valid   = 1'b0;
        bus.duty_target = 8'd20;
        measure_busy(n);
        chk("s5_ovr_busy_cycles", n, exp_busy(C_FORWARD, 50, C_RIGHT, 30));
        chk("s5_ovr_cur_cmd", int'(cur_cmd), C_RIGHT);
        chk("s5_nav_ready_in_run", int'(bus.nav_ready), 1);
        @(posedge clk);
        #1;
        bus.nav_valid = 1'b0;
        m_cmd = C_RIGHT;
        m_duty = 30;
        measure_busy(n);
        chk("s5_nav_busy_cycles", n + 1, exp_busy(C_RIGHT, 30, C_LEFT, 20) + 1);
        m_cmd = C_LEFT;
        m_duty = 20;
        chk("s5_nav_cur_cmd", int'(cur_cmd), C_LEFT);
        check_pwm("s5_left");

        // 6: reset in the middle of RAMP_DOWN
        issue(1'b0, C_FORWARD, 100);
        repeat (20) @(negedge clk);
        chk("s6_busy_before_reset", int'(busy), 1);
        #1;
        mon_en = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        chk("s6_outputs", int'({a_fwd, a_rev, b_fwd, b_rev}), 0);
        chk("s6_busy", int'(busy), 0);
        chk("s6_cur_cmd", int'(cur_cmd), C_STOP);
        chk("s6_nav_ready_idle", int'(bus.nav_ready), 1);
        reset = 1'b0;
        m_cmd = C_STOP;
        m_duty = 0;
        repeat (2) @(negedge clk);
        #1 mon_en = 1'b1;

        // Randomised command sequence against the model
        for (int it = 0; it < 8; it++) begin
            int c, d;
            bit o;
            c = int'($urandom_range(0, 3));
            d = int'($urandom_range(0, 60));
            o = 1'($urandom_range(0, 1));
            if (o && c == C_STOP && m_cmd == C_STOP) o = 1'b0;
            step(o, c, d, "rand");
        end

        @(negedge clk);
        #1;
        chk("no_shoot_through", overlap, 0);
        checks++;
        assert (dead_seen > 0 && min_dead >= DC) else begin
            errors++;
            $error("FAIL dead_time: observed min zero run %0d over %0d changes, expected at least %0d", min_dead, dead_seen, DC);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/motor_drive_sequencer.md
# motor_drive_sequencer

Sequences the drive motors between motion commands. It arbitrates between the navigation FSM and an override requester. On every direction change it ramps the PWM duty down, inserts a dead time with all bridge inputs low, loads the new direction, then ramps duty up to the commanded level. It sits between the steering logic and the H-bridge pins and owns the shared PWM generator.

## Interface
- PWM_PRESCALE, 39: clk cycles per PWM counter step (PWM period = 256 × PWM_PRESCALE = 9984 cycles).
- RAMP_DIV, 16: clk cycles per ±1 duty step during ramps.
- DEAD_CYCLES, 500: cycles with all motor outputs low between directions.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- nav_valid  in  1  navigation command valid.
- nav_cmd  in  2  navigation command.
- nav_ready  out  1  navigation command accepted this cycle when high with nav_valid.
- ovr_valid  in  1  override command valid.
- ovr_cmd  in  2  override command.
- ovr_ready  out  1  always 1; override is never refused.
- duty_target  in  8  target duty, latched on acceptance.
- motor_a_fwd, motor_a_rev, motor_b_fwd, motor_b_rev  out  1 each  registered H-bridge inputs.
- cur_cmd  out  2  direction currently driven.
- busy  out  1  high in RAMP_DOWN, DEAD and RAMP_UP.

## Operation
- Command encoding: 00 STOP, 01 FORWARD (A fwd, B fwd), 10 RIGHT (A fwd, B rev), 11 LEFT (A rev, B fwd).
- States:
  - IDLE: stopped, cur_cmd=STOP.
  - RAMP_DOWN.
  - DEAD.
  - RAMP_UP.
  - RUN.
- Arbitration:
  - nav_ready = (IDLE or RUN) and not ovr_valid.
  - Override has strict priority and is accepted in any state.
- Accepting a command equal to cur_cmd in RUN or IDLE: the handshake completes and nothing else changes. duty_target is ignored.
- Accepting a different command:
  - Latch pending_cmd and pending_duty.
  - RUN → RAMP_DOWN.
  - IDLE → RAMP_DOWN, which exits on its first cycle because duty is 0.
- RAMP_DOWN: duty decrements by 1 every RAMP_DIV cycles. At duty 0, go to DEAD.
- DEAD:
  - All four outputs are 0 for exactly DEAD_CYCLES cycles.
  - Then cur_cmd ← pending_cmd.
  - pending STOP → IDLE; otherwise → RAMP_UP.
- RAMP_UP: duty increments by 1 every RAMP_DIV cycles until it equals pending_duty, then RUN. pending_duty=0 enters RUN immediately.
- Override other than STOP in RAMP_DOWN, RAMP_UP or RUN: replaces the pending command and duty, then enters or continues RAMP_DOWN.
- Override other than STOP in DEAD: replaces the pending command and duty. The dead counter is not restarted.
- Override STOP in any state:
  - Duty forced to 0.
  - Outputs low on the next cycle.
  - Enter DEAD with pending STOP, so the block ends in IDLE. This is the emergency stop.
- PWM:
  - Free-running prescaler and 8-bit counter, never reset by commands.
  - pwm_on = duty > pwm_cnt, so duty 255 gives 255/256 on-time and duty 0 never turns on.
  - Each motor output = direction bit of cur_cmd AND pwm_on.
  - An fwd and rev pair is never high together, in any state.

## Timing
- Reset state:
  - Values: state IDLE, duty 0, pwm_cnt 0, prescaler 0, cur_cmd STOP.
  - Outputs: all motor outputs 0, busy 0.
  - Reset mid-operation takes effect at the next edge with no ramp-down.
- Motor outputs are registered, with 1 cycle latency from the duty/pwm_cnt compare.
- The ramp tick counter restarts on entry to RAMP_UP and RAMP_DOWN.
- Ramp from duty 0 to D takes D × RAMP_DIV cycles.
- Command acceptance to first non-zero output, from IDLE: 1 (RAMP_DOWN) + DEAD_CYCLES + ramp progress + PWM phase.
- nav_ready and ovr_ready are combinational from state and ovr_valid.
- All other outputs are registered.
- Duty arithmetic is 8-bit, saturating at 0 and 255. There is no wrap-around.

## Structure
- Package motor_pkg holds:
  - Command localparams STOP, FORWARD, RIGHT, LEFT.
  - The state enum.
  - A function mapping a command to the 4-bit direction mask.
- Sub-module pwm_gen contains the prescaler, the 8-bit counter and the compare. Its inputs are duty[7:0] and its output is pwm_on.

## Test plan
Parameters for all scenarios: PWM_PRESCALE=1, RAMP_DIV=4, DEAD_CYCLES=8.
1. Reset, then nav FORWARD with duty 128 → nav_ready=1, 1 cycle RAMP_DOWN, 8 cycles of all outputs 0, 512 cycles of RAMP_UP, then RUN. a_fwd and b_fwd are each high 128 of 256 cycles; both rev outputs stay 0.
2. In RUN FORWARD at duty 128, nav RIGHT → duty reaches 0 after 512 cycles, then 8 cycles of all outputs 0, then b_rev pulses. b_fwd and b_rev are never high together.
3. In RUN FORWARD, resubmit nav FORWARD with duty 200 → accepted, busy stays 0, duty stays 128.
4. Override STOP during RAMP_UP at duty 40 → all outputs 0 on the next cycle, 8 DEAD cycles, then IDLE with cur_cmd=STOP.
5. In RUN, nav_valid and ovr_valid both high → override accepted, nav_ready=0, and the nav command stays pending.
6. Reset asserted mid RAMP_DOWN → all outputs 0 and IDLE on the next cycle, busy=0.
